// File: rtl/stream_mux_nchan.sv
// N-channel valid/ready stream mux with a single registered output stage.
// Optional packet lock (grant held until In_Last) under STREAM_MUX_PKT_LOCK_EN.
//
// state | meaning
// EMPTY | output register holds no beat (Out_Valid=0)
// FULL  | output register holds a beat awaiting Out_Ready
module stream_mux_nchan #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [CHANNELS*WIDTH-1:0] I,
  input  logic [CHANNELS-1:0]       In_Valid,
  output logic [CHANNELS-1:0]       In_Ready,
  input  logic [SEL_W-1:0]          Select_Line,
  input  logic                      Mode,
`ifdef STREAM_MUX_PKT_LOCK_EN
  input  logic [CHANNELS-1:0]       In_Last,
  output logic                      Out_Last,
`endif
  output logic [WIDTH-1:0]          Out,
  output logic                      Out_Valid,
  input  logic                      Out_Ready,
  output logic [SEL_W-1:0]          Out_Channel,
  output logic                      Sel_Error
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   out_q;
  logic [SEL_W-1:0]   ch_q;
  logic [SEL_W-1:0]   ptr_q;
  logic               err_q;

  logic               load_en;
  logic               grant_vld;
  logic [SEL_W-1:0]   grant;
  logic [WIDTH-1:0]   data_sel;
  logic               accept;
  logic               sel_oor;
  logic [SEL_W-1:0]   ptr_next;

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic               lock_q;
  logic [SEL_W-1:0]   lock_ch_q;
  logic               last_q;
  logic               last_sel;
`endif

  assign Out_Valid   = (state_q == FULL);
  assign Out         = out_q;
  assign Out_Channel = ch_q;
  assign Sel_Error   = err_q;

  assign load_en  = !Out_Valid || Out_Ready;
  assign sel_oor  = (int'(Select_Line) >= CHANNELS);
  assign accept   = grant_vld && load_en;
  assign ptr_next = SEL_W'((int'(grant) + 1) % CHANNELS);

  // Grant selection: lock (if enabled) overrides both fixed and round-robin modes
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
    if (lock_q) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (lock_ch_q == SEL_W'(c) && In_Valid[c]) begin
          grant_vld = 1'b1;
          grant     = SEL_W'(c);
        end
      end
    end else
`endif
    if (!Mode) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (Select_Line == SEL_W'(c) && In_Valid[c]) begin
          grant_vld = 1'b1;
          grant     = SEL_W'(c);
        end
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (!grant_vld && In_Valid[(int'(ptr_q) + k) % CHANNELS]) begin
          grant_vld = 1'b1;
          grant     = SEL_W'((int'(ptr_q) + k) % CHANNELS);
        end
      end
    end
  end

  always_comb begin
    data_sel = '0;
    In_Ready = '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
    last_sel = 1'b0;
`endif
    for (int c = 0; c < CHANNELS; c++) begin
      if (grant == SEL_W'(c)) begin
        data_sel    = I[c*WIDTH +: WIDTH];
        In_Ready[c] = grant_vld && load_en && !Reset;
`ifdef STREAM_MUX_PKT_LOCK_EN
        last_sel    = In_Last[c];
`endif
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (load_en) begin
      state_d = grant_vld ? FULL : EMPTY;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= EMPTY;
      out_q   <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        out_q <= data_sel;
        ch_q  <= grant;
      end
      if (accept && Mode) begin
        ptr_q <= ptr_next;
      end
      if (!Mode && sel_oor) begin
        err_q <= 1'b1;
      end
    end
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  assign Out_Last = last_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
      last_q    <= 1'b0;
    end else if (accept) begin
      lock_q    <= !last_sel;
      lock_ch_q <= grant;
      last_q    <= last_sel;
    end
  end
`endif

endmodule
